// File: rtl/snake_dir_arbiter.sv
// Turns debounced direction buttons into one committed snake heading, releasing at most one per tick.
// Define SNAKE_DIR_QUEUE_EN for a 2-entry request FIFO; otherwise a single overwritable slot is used.
module snake_dir_arbiter #(
  parameter logic [1:0] INIT_DIR = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       dir_update,
  output logic [1:0] q_count,
  output logic       overflow
);

  logic [3:0] btn, prev, press;
  logic [1:0] cand, tail, head;
  logic       any_press, valid, pop, push;
  logic [1:0] dir_nxt, head_nxt, count_nxt;
  logic       update_nxt, overflow_nxt;
`ifdef SNAKE_DIR_QUEUE_EN
  logic [1:0] slot, slot_nxt;
`endif

  assign btn   = {btn_up, btn_down, btn_left, btn_right};
  assign press = btn & ~prev;

  // Fixed priority up > down > left > right; losers are simply dropped.
  always_comb begin
    cand      = 2'b00;
    any_press = 1'b1;
    if (press[3])      cand = 2'b00;
    else if (press[2]) cand = 2'b01;
    else if (press[1]) cand = 2'b10;
    else if (press[0]) cand = 2'b11;
    else               any_press = 1'b0;
  end

  always_comb begin
    dir_nxt      = dir;
    head_nxt     = head;
    count_nxt    = q_count;
    update_nxt   = 1'b0;
    overflow_nxt = overflow;
`ifdef SNAKE_DIR_QUEUE_EN
    slot_nxt = slot;
    tail     = (q_count == 2'd2) ? slot : (q_count == 2'd1) ? head : dir;
`else
    tail     = dir;
`endif
    valid = any_press && (cand != tail) && (cand != (tail ^ 2'b01));
    pop   = tick && (q_count != 2'd0);
`ifdef SNAKE_DIR_QUEUE_EN
    push         = valid && ((q_count != 2'd2) || tick);
    overflow_nxt = overflow | (valid & ~push);
`else
    push         = valid;
    overflow_nxt = 1'b0;
`endif
    if (pop) begin
      dir_nxt    = head;
      update_nxt = (head != dir);
    end
`ifdef SNAKE_DIR_QUEUE_EN
    // A pop only ever sees pre-edge contents, so a same-edge push lands behind it.
    case ({pop, push})
      2'b10: begin
        head_nxt  = slot;
        count_nxt = q_count - 2'd1;
      end
      2'b01: begin
        if (q_count == 2'd0) head_nxt = cand;
        else                 slot_nxt = cand;
        count_nxt = q_count + 2'd1;
      end
      2'b11: begin
        if (q_count == 2'd1) begin
          head_nxt = cand;
        end else begin
          head_nxt = slot;
          slot_nxt = cand;
        end
      end
      default: ;
    endcase
`else
    if (push) begin
      head_nxt  = cand;
      count_nxt = 2'd1;
    end else if (pop) begin
      count_nxt = 2'd0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= 4'b1111;
      dir        <= INIT_DIR;
      head       <= 2'b00;
      q_count    <= 2'd0;
      dir_update <= 1'b0;
      overflow   <= 1'b0;
`ifdef SNAKE_DIR_QUEUE_EN
      slot       <= 2'b00;
`endif
    end else begin
      prev       <= btn;
      dir        <= dir_nxt;
      head       <= head_nxt;
      q_count    <= count_nxt;
      dir_update <= update_nxt;
      overflow   <= overflow_nxt;
`ifdef SNAKE_DIR_QUEUE_EN
      slot       <= slot_nxt;
`endif
    end
  end

endmodule
